// File: rtl/sne_evt_stream_pkg.sv
// Shared event-stream types: spike payload, stream beat and lane level.
// evt_lane_level_t is sized from EVT_SKID_DEPTH; keep SKID_DEPTH equal to it.
package sne_evt_stream_pkg;

    localparam int unsigned SPIKE_W        = 8;
    localparam int unsigned EVT_SKID_DEPTH = 4;
    localparam int unsigned EVT_LVL_W      = $clog2(EVT_SKID_DEPTH + 1);

    typedef logic [SPIKE_W-1:0] spike_t;

    typedef struct packed {
        spike_t spike;
    } sne_evt_t;

    typedef logic [EVT_LVL_W-1:0] evt_lane_level_t;

endpackage

// File: rtl/sne_event_stream_if.sv
// Valid/ready event stream carrying one sne_evt_t per beat.
// src drives valid/evt and samples ready; dst is the mirror.
interface SNE_EVENT_STREAM;
    import sne_evt_stream_pkg::*;

    logic     valid;
    logic     ready;
    sne_evt_t evt;

    modport src (output valid, output evt, input ready);
    modport dst (input valid, input evt, output ready);

endinterface

// File: rtl/evt_lane_fifo.sv
// Single-lane skid FIFO, DEPTH entries (power of two), registered level.
// Ports: clk, rst (active-low async), flush, push/data, pop/head, empty/full/level.
module evt_lane_fifo
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  spike_t                       data,
    input  logic                         pop,
    output spike_t                       head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    spike_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LW'(DEPTH));
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      cnt <= cnt + LW'(1);
            else if (do_pop && !do_push) cnt <= cnt - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/evt_lane_skid_mapper.sv
// Maps DP_GROUP upstream event lanes into independent per-lane skid FIFOs.
// Ports: engine_clk_i, engine_rst_ni, flush_i, evt_valid_i, evt_spike_i,
//   spike_grant_o, lane_level_o, evt_fifo_stream_src[], and stall_cnt_o
//   when EVT_MAPPER_STATS_EN is defined.
module evt_lane_skid_mapper
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned DP_GROUP   = 16,
    parameter int unsigned SKID_DEPTH = EVT_SKID_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                 engine_clk_i,
    input  logic                                 engine_rst_ni,
    input  logic                                 flush_i,
    input  logic [DP_GROUP-1:0]                  evt_valid_i,
    input  spike_t [DP_GROUP-1:0]                evt_spike_i,
    output logic                                 spike_grant_o,
    output evt_lane_level_t [DP_GROUP-1:0]       lane_level_o,
    SNE_EVENT_STREAM.src                         evt_fifo_stream_src [DP_GROUP]
`ifdef EVT_MAPPER_STATS_EN
    ,
    output logic [CNT_W-1:0]                     stall_cnt_o
`endif
);

    logic [DP_GROUP-1:0] lane_full;
    logic [DP_GROUP-1:0] lane_empty;
    logic [DP_GROUP-1:0] lane_push;
    logic [DP_GROUP-1:0] lane_pop;
    logic [DP_GROUP-1:0] lane_ready;

    // Grant depends only on registered fill levels, never on downstream ready.
    assign spike_grant_o = ~|lane_full;

    for (genvar i = 0; i < DP_GROUP; i++) begin : g_lane
        spike_t head;

        assign lane_ready[i] = evt_fifo_stream_src[i].ready;
        assign lane_push[i]  = evt_valid_i[i] & spike_grant_o & ~flush_i;
        assign lane_pop[i]   = ~lane_empty[i] & lane_ready[i];

        assign evt_fifo_stream_src[i].valid     = ~lane_empty[i];
        assign evt_fifo_stream_src[i].evt.spike = head;

        evt_lane_fifo #(
            .DEPTH (SKID_DEPTH)
        ) u_fifo (
            .clk   (engine_clk_i),
            .rst   (engine_rst_ni),
            .flush (flush_i),
            .push  (lane_push[i]),
            .data  (evt_spike_i[i]),
            .pop   (lane_pop[i]),
            .head  (head),
            .empty (lane_empty[i]),
            .full  (lane_full[i]),
            .level (lane_level_o[i])
        );
    end

`ifdef EVT_MAPPER_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
        if (!engine_rst_ni) begin
            stall_cnt_q <= '0;
        end else if (flush_i) begin
            stall_cnt_q <= '0;
        end else if (!spike_grant_o && |evt_valid_i && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_evt_lane_skid_mapper.sv
// Self-checking bench for evt_lane_skid_mapper: directed scenarios plus
// randomized traffic against a per-lane queue reference model.
module tb_evt_lane_skid_mapper;
    import sne_evt_stream_pkg::*;

    localparam int DP = 16;
    localparam int D  = EVT_SKID_DEPTH;
    localparam int CW = 16;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [DP-1:0]            vld;
    spike_t [DP-1:0]          spk;
    logic                     grant;
    evt_lane_level_t [DP-1:0] lvl;
    logic [DP-1:0]            rdy;
    logic [DP-1:0]            ovld;
    spike_t [DP-1:0]          ospk;
`ifdef EVT_MAPPER_STATS_EN
    logic [CW-1:0]            stall;
`endif

    int checks;
    int failures;

    spike_t        mq [DP][$];
    logic [CW-1:0] m_stall;

    SNE_EVENT_STREAM strm [DP] ();

    for (genvar g = 0; g < DP; g++) begin : g_map
        assign ovld[g]        = strm[g].valid;
        assign ospk[g]        = strm[g].evt.spike;
        assign strm[g].ready  = rdy[g];
    end

    evt_lane_skid_mapper #(
        .DP_GROUP   (DP),
        .SKID_DEPTH (D),
        .CNT_W      (CW)
    ) dut (
        .engine_clk_i        (clk),
        .engine_rst_ni       (rst_n),
        .flush_i             (flush),
        .evt_valid_i         (vld),
        .evt_spike_i         (spk),
        .spike_grant_o       (grant),
        .lane_level_o        (lvl),
        .evt_fifo_stream_src (strm)
`ifdef EVT_MAPPER_STATS_EN
        ,
        .stall_cnt_o         (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_grant();
        for (int i = 0; i < DP; i++)
            if (mq[i].size() >= D) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DP; i++) mq[i].delete();
        m_stall = '0;
    endtask

    // Advance one clock; the model applies the rules to the inputs now applied.
    task automatic tick();
        bit g;
        g = m_grant();
        if (rst_n) begin
            if (flush) begin
                m_clear();
            end else begin
                if (!g && |vld && m_stall != '1) m_stall++;
                for (int i = 0; i < DP; i++)
                    if (mq[i].size() > 0 && rdy[i]) void'(mq[i].pop_front());
                for (int i = 0; i < DP; i++)
                    if (vld[i] && g) mq[i].push_back(spk[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        vld   = '0;
        spk   = '0;
        rdy   = '1;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (grant !== 1'b1) begin
            failures++;
            $display("FAIL reset_grant got=%b exp=1", grant);
        end
        checks++;
        if (ovld !== '0) begin
            failures++;
            $display("FAIL reset_valid got=%h exp=0", ovld);
        end
        checks++;
        if (lvl !== '0) begin
            failures++;
            $display("FAIL reset_level got=%h exp=0", lvl);
        end
        // Buffer two events on lane 2, then reset mid-operation.
        rdy    = '0;
        vld    = DP'(1) << 2;
        spk[2] = 8'h33;
        tick();
        tick();
        vld = '0;
        checks++;
        if (lvl[2] !== EVT_LVL_W'(2)) begin
            failures++;
            $display("FAIL prereset_level got=%0d exp=2", lvl[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (lvl !== '0 || ovld !== '0 || grant !== 1'b1) begin
            failures++;
            $display("FAIL async_reset lvl=%h vld=%h grant=%b exp=0/0/1",
                     lvl, ovld, grant);
        end
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (lvl[2] !== '0 || ovld[2] !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard lvl=%0d vld=%b exp=0/0", lvl[2], ovld[2]);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        vld[3] = 1'b1;
        spk[3] = 8'h15;
        checks++;
        if (ovld[3] !== 1'b0) begin
            failures++;
            $display("FAIL latency_bypass got=%b exp=0", ovld[3]);
        end
        tick();
        vld = '0;
        checks++;
        if (ovld[3] !== 1'b1 || ospk[3] !== 8'h15) begin
            failures++;
            $display("FAIL latency_n1 vld=%b spk=%h exp=1/15", ovld[3], ospk[3]);
        end
        tick();
        checks++;
        if (lvl[3] !== '0 || ovld[3] !== 1'b0) begin
            failures++;
            $display("FAIL latency_n2 lvl=%0d vld=%b exp=0/0", lvl[3], ovld[3]);
        end
    endtask

    task automatic test_full();
        apply_reset();
        rdy[0] = 1'b0;
        for (int k = 0; k < D; k++) begin
            vld    = DP'(3);
            spk[0] = spike_t'(k);
            spk[1] = spike_t'(8'h40 + k);
            tick();
        end
        vld = '0;
        checks++;
        if (lvl[0] !== EVT_LVL_W'(D) || grant !== 1'b0) begin
            failures++;
            $display("FAIL full_level lvl=%0d grant=%b exp=%0d/0", lvl[0], grant, D);
        end
        vld = DP'(2);
        tick();
        vld = '0;
        checks++;
        if (lvl[1] !== '0 || ovld[1] !== 1'b0) begin
            failures++;
            $display("FAIL full_drain lvl=%0d vld=%b exp=0/0", lvl[1], ovld[1]);
        end
        checks++;
        if (lvl[0] !== EVT_LVL_W'(D) || ospk[0] !== 8'h00 || grant !== 1'b0) begin
            failures++;
            $display("FAIL full_hold lvl=%0d spk=%h grant=%b exp=%0d/00/0",
                     lvl[0], ospk[0], grant, D);
        end
    endtask

    task automatic test_release();
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        checks++;
        if (grant !== 1'b1 || lvl[0] !== EVT_LVL_W'(D - 1)) begin
            failures++;
            $display("FAIL release grant=%b lvl=%0d exp=1/%0d", grant, lvl[0], D - 1);
        end
        rdy[0] = 1'b1;
        for (int k = 1; k < D; k++) begin
            checks++;
            if (ovld[0] !== 1'b1 || ospk[0] !== spike_t'(k)) begin
                failures++;
                $display("FAIL release_order vld=%b spk=%h exp=1/%h",
                         ovld[0], ospk[0], spike_t'(k));
            end
            tick();
        end
        checks++;
        if (lvl[0] !== '0) begin
            failures++;
            $display("FAIL release_empty lvl=%0d exp=0", lvl[0]);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        rdy    = '0;
        vld[5] = 1'b1;
        spk[5] = 8'hA1;
        tick();
        spk[5] = 8'hA2;
        tick();
        rdy[5] = 1'b1;
        spk[5] = 8'hA3;
        checks++;
        if (lvl[5] !== EVT_LVL_W'(2) || ospk[5] !== 8'hA1) begin
            failures++;
            $display("FAIL pp_pre lvl=%0d spk=%h exp=2/a1", lvl[5], ospk[5]);
        end
        tick();
        vld = '0;
        checks++;
        if (lvl[5] !== EVT_LVL_W'(2) || ospk[5] !== 8'hA2) begin
            failures++;
            $display("FAIL pp_same lvl=%0d spk=%h exp=2/a2", lvl[5], ospk[5]);
        end
        tick();
        checks++;
        if (lvl[5] !== EVT_LVL_W'(1) || ospk[5] !== 8'hA3) begin
            failures++;
            $display("FAIL pp_tail lvl=%0d spk=%h exp=1/a3", lvl[5], ospk[5]);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        rdy[0] = 1'b0;
        vld    = DP'(1);
        for (int k = 0; k < D; k++) tick();
        vld = DP'(16'h00F1);
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (grant !== 1'b0 || lvl[4] !== '0) begin
            failures++;
            $display("FAIL flush_stalled grant=%b lvl4=%0d exp=0/0", grant, lvl[4]);
        end
`ifdef EVT_MAPPER_STATS_EN
        checks++;
        if (stall !== CW'(10)) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=10", stall);
        end
`endif
        flush = 1'b1;
        vld   = '1;
        rdy   = '1;
        for (int i = 0; i < DP; i++) spk[i] = spike_t'($urandom);
        tick();
        flush = 1'b0;
        vld   = '0;
        checks++;
        if (ovld !== '0 || lvl !== '0 || grant !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear vld=%h lvl=%h grant=%b exp=0/0/1",
                     ovld, lvl, grant);
        end
`ifdef EVT_MAPPER_STATS_EN
        checks++;
        if (stall !== '0) begin
            failures++;
            $display("FAIL stall_flush got=%0d exp=0", stall);
        end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (grant !== m_grant()) begin
                failures++;
                $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, m_grant());
            end
            for (int i = 0; i < DP; i++) begin
                checks++;
                if (lvl[i] !== EVT_LVL_W'(mq[i].size())) begin
                    failures++;
                    $display("FAIL rnd_level c=%0d lane=%0d got=%0d exp=%0d",
                             c, i, lvl[i], mq[i].size());
                end
                checks++;
                if (ovld[i] !== (mq[i].size() > 0)) begin
                    failures++;
                    $display("FAIL rnd_valid c=%0d lane=%0d got=%b exp=%b",
                             c, i, ovld[i], mq[i].size() > 0);
                end else if (mq[i].size() > 0) begin
                    checks++;
                    if (ospk[i] !== mq[i][0]) begin
                        failures++;
                        $display("FAIL rnd_spike c=%0d lane=%0d got=%h exp=%h",
                                 c, i, ospk[i], mq[i][0]);
                    end
                end
            end
`ifdef EVT_MAPPER_STATS_EN
            checks++;
            if (stall !== m_stall) begin
                failures++;
                $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall, m_stall);
            end
`endif
            for (int i = 0; i < DP; i++) begin
                vld[i] = ($urandom_range(0, 9) < 7);
                rdy[i] = ($urandom_range(0, 9) < 4);
                spk[i] = spike_t'($urandom);
            end
            flush = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0;
        vld   = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        vld      = '0;
        spk      = '0;
        rdy      = '1;
        m_stall  = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_full();
        test_release();
        test_push_pop();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/evt_lane_skid_mapper.md
EVT_LANE_SKID_MAPPER -- requirements
Module: evt_lane_skid_mapper

Interface
REQ-001 SHALL have parameter DP_GROUP, default 16: number of event lanes.
REQ-002 SHALL have parameter SKID_DEPTH, default 4: entries per lane buffer; power of two, >=2.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port engine_clk_i, input, 1: the only clock.
REQ-005 SHALL have port engine_rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1: synchronous clear of all lane buffers.
REQ-007 SHALL have port evt_valid_i, input, DP_GROUP: per-lane upstream valid.
REQ-008 SHALL have port evt_spike_i, input, spike_t[DP_GROUP]: per-lane upstream spike.
REQ-009 SHALL have port spike_grant_o, output, 1: group accept; all lanes can take one event.
REQ-010 SHALL have port lane_level_o, output, DP_GROUP x $clog2(SKID_DEPTH+1): per-lane occupancy.
REQ-011 SHALL have port evt_fifo_stream_src, SNE_EVENT_STREAM.src[DP_GROUP]: downstream lanes (valid, evt.spike out; ready in).
REQ-012 SHALL have port stall_cnt_o, output, CNT_W: grant-low cycle count (present only with EVT_MAPPER_STATS_EN).

Function
REQ-013 SHALL give each lane an independent FIFO of SKID_DEPTH entries; lanes never block one another downstream.
REQ-014 SHALL drive spike_grant_o = 1 iff no lane is full, from registered occupancy only (no combinational path from any downstream ready).
REQ-015 SHALL push lane i iff evt_valid_i[i] & spike_grant_o & ~flush_i; invalid lanes in a granted cycle push nothing.
REQ-016 SHALL drive lane i valid = lane not empty and evt.spike = head entry; pop iff valid & ready.
REQ-017 SHALL give 1-cycle latency: an event pushed in cycle N is visible downstream in cycle N+1 (no same-cycle bypass).
REQ-018 SHALL, on simultaneous push and pop, keep occupancy unchanged and keep FIFO order.
REQ-019 SHALL keep valid and spike of a lane stable while valid & ~ready (stream protocol).
REQ-020 SHALL wrap read/write pointers modulo SKID_DEPTH; occupancy ranges 0..SKID_DEPTH.
REQ-021 SHALL, when flush_i=1, zero every pointer and occupancy on the next edge, ignore same-cycle push/pop, and drive all lane valid = 0 the following cycle.
REQ-022 SHALL deassert spike_grant_o the cycle after any lane reaches SKID_DEPTH and reassert it the cycle after that lane pops.

Reset
REQ-023 SHALL, on engine_rst_ni low, asynchronously clear pointers, occupancy and stall counter; spike_grant_o = 1, all lane valid = 0, lane_level_o = 0.
REQ-024 SHALL discard all buffered events when reset asserts mid-operation; storage contents need no reset.

Configuration
REQ-025 SHALL, with EVT_MAPPER_STATS_EN defined, increment stall_cnt_o each cycle spike_grant_o = 0 and any evt_valid_i bit = 1, saturating at all-ones, cleared by flush_i.
REQ-026 SHALL, without EVT_MAPPER_STATS_EN, omit stall_cnt_o and its counter logic entirely.

Structure
REQ-027 SHALL take spike_t from sne_evt_stream_pkg; the package SHALL also hold evt_lane_level_t type used for lane_level_o.
REQ-028 SHALL instantiate sub-module evt_lane_fifo (one per lane via generate; ports: clk, rst, flush, push, data, pop, head, empty, full, level).

Verification
REQ-029 SHALL check reset: after release, spike_grant_o=1, all lane valid=0, lane_level_o all 0.
REQ-030 SHALL check latency: lane 3 push spike 0x15 at cycle N, ready=1 -> lane 3 valid with 0x15 at N+1, level back to 0 at N+2.
REQ-031 SHALL check full: lane 0 ready=0, 4 pushes (SKID_DEPTH=4) -> level 4, grant=0 next cycle; other lanes keep draining.
REQ-032 SHALL check release: from full, lane 0 ready=1 one cycle -> grant=1 next cycle; order 0,1,2,3 preserved.
REQ-033 SHALL check push+pop at level 2 -> level stays 2, output order unchanged.
REQ-034 SHALL check flush with stats: 10 stalled cycles -> stall_cnt_o=10; flush_i -> all valid=0, stall_cnt_o=0 next cycle.
